// File: rtl/bp_nonsynth_cache_resp_collector.sv
// Per-channel response buffers with random release stalls, outstanding
// request tracking, a global watchdog and sticky pass/fail run flags.
module bp_nonsynth_cache_resp_collector #(
  parameter int num_channels_p  = 1,
  parameter int data_width_p    = 64,
  parameter int fifo_els_p      = 8,
  parameter int max_stall_p     = 15,
  parameter int timeout_width_p = 16,
  parameter int lfsr_width_p    = 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        random_mode_i,
  input  logic [num_channels_p-1:0]                   req_v_i,
  input  logic [num_channels_p-1:0]                   v_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0] data_i,
  output logic [num_channels_p-1:0]                   ready_o,
  output logic [num_channels_p-1:0]                   v_o,
  output logic [num_channels_p-1:0][data_width_p-1:0] data_o,
  input  logic [num_channels_p-1:0]                   yumi_i,
  input  logic [num_channels_p-1:0]                   done_i,
  output logic                                        pass_o,
  output logic                                        fail_o,
  output logic                                        timeout_o,
  output logic [num_channels_p-1:0]                   underflow_o
);
  localparam int NC = num_channels_p;
  localparam int DW = data_width_p;
  localparam int PW = $clog2(fifo_els_p);
  localparam int CW = PW + 2;
  localparam int SW = (max_stall_p > 0) ? $clog2(max_stall_p + 1) : 1;
  localparam int LW = lfsr_width_p;
  localparam int TW = timeout_width_p;

  function automatic logic [31:0] taps_f(input int w);
    unique case (w)
      3:       taps_f = 32'h6;
      4:       taps_f = 32'hC;
      5:       taps_f = 32'h14;
      6:       taps_f = 32'h30;
      7:       taps_f = 32'h60;
      8:       taps_f = 32'hB8;
      9:       taps_f = 32'h110;
      10:      taps_f = 32'h240;
      11:      taps_f = 32'h500;
      12:      taps_f = 32'h829;
      13:      taps_f = 32'h100D;
      14:      taps_f = 32'h2015;
      15:      taps_f = 32'h6000;
      16:      taps_f = 32'hD008;
      default: taps_f = 32'h3 << (w - 2);
    endcase
  endfunction

  localparam logic [LW-1:0] TAPS = LW'(taps_f(LW));

  logic [NC-1:0] empty_w;
  logic [NC-1:0] outz_w;
  logic [NC-1:0] enq_w;
  logic [NC-1:0] deq_w;

  for (genvar i = 0; i < NC; i++) begin : g_ch
    logic [DW-1:0] mem_q [fifo_els_p];
    logic [PW:0]   wptr_q, wptr_d;
    logic [PW:0]   rptr_q, rptr_d;
    logic [CW-1:0] out_q, out_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [LW-1:0] lfsr_q, lfsr_d;
    logic          rdy_q, rdy_d;
    logic          uf_q, uf_d;
    logic          head;

    assign empty_w[i]     = (wptr_q == rptr_q);
    assign outz_w[i]      = (out_q == '0);
    assign enq_w[i]       = v_i[i] & rdy_q;
    assign deq_w[i]       = yumi_i[i] & v_o[i];
    assign v_o[i]         = ~empty_w[i] & (stall_q == '0);
    assign ready_o[i]     = rdy_q;
    assign underflow_o[i] = uf_q;
    assign data_o[i]      = v_o[i] ? mem_q[rptr_q[PW-1:0]] : '0;

    always_comb begin
      wptr_d  = wptr_q + (PW+1)'(enq_w[i]);
      rptr_d  = rptr_q + (PW+1)'(deq_w[i]);
      rdy_d   = ~((wptr_d[PW] != rptr_d[PW]) &&
                  (wptr_d[PW-1:0] == rptr_d[PW-1:0]));
      // a new head is either the first entry or the one behind a dequeue
      head    = (enq_w[i] && empty_w[i]) ||
                (deq_w[i] && (wptr_d != rptr_d));
      stall_d = stall_q;
      if (head) begin
        stall_d = random_mode_i
                ? SW'(32'(lfsr_q) % (max_stall_p + 1)) : '0;
      end else if (!empty_w[i] && stall_q != '0) begin
        stall_d = stall_q - SW'(1);
      end
      out_d = out_q;
      uf_d  = uf_q;
      if (req_v_i[i] && !enq_w[i]) begin
        if (out_q != '1) out_d = out_q + CW'(1);
      end else if (enq_w[i] && !req_v_i[i]) begin
        if (out_q == '0) uf_d = 1'b1;
        else out_d = out_q - CW'(1);
      end
      lfsr_d = {lfsr_q[LW-2:0], ^(lfsr_q & TAPS)};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        out_q   <= '0;
        stall_q <= '0;
        lfsr_q  <= LW'(i + 1);
        rdy_q   <= 1'b1;
        uf_q    <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        out_q   <= out_d;
        stall_q <= stall_d;
        lfsr_q  <= lfsr_d;
        rdy_q   <= rdy_d;
        uf_q    <= uf_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq_w[i]) mem_q[wptr_q[PW-1:0]] <= data_i[i];
    end
  end

  logic [TW-1:0] wd_q, wd_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          to_q, to_d;
  logic          act, wd_hit, pass_c, fail_c;

  always_comb begin
    act  = (|req_v_i) | (|enq_w) | (|deq_w);
    wd_d = wd_q;
    if (act) wd_d = '0;
    else if (wd_q != '1) wd_d = wd_q + TW'(1);
    wd_hit = (wd_d == '1);
    pass_c = (&done_i) & (&empty_w) & (&outz_w) & ~(|underflow_o);
    fail_c = (|underflow_o) | wd_hit;
    pass_d = pass_q;
    fail_d = fail_q;
    to_d   = to_q;
    // fail outranks pass when both appear in the same cycle
    if (!pass_q && !fail_q) begin
      if (fail_c) begin
        fail_d = 1'b1;
        to_d   = wd_hit;
      end else if (pass_c) begin
        pass_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_q   <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      to_q   <= to_d;
    end
  end

  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = to_q;

endmodule
